// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern detector: FSM encoding, default
// geometry and the fill-counter width helper.
package seq_pkg;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;
  localparam int unsigned DEF_CNT_W   = 8;

  // Bits needed to count 0..width accepted bits.
  function automatic int unsigned fill_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in parallel-out shift register with enable; newest bit enters at LSB.
module sipo_shreg
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= {q_q[WIDTH-2:0], din};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: windows the qualified bit stream, pulses match on
// detection and keeps a saturating match count.
module seq_detector
  import seq_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic [WIDTH-1:0] window,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned       FILL_W    = fill_cnt_w(WIDTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              armed_q, armed_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  win;
  logic [WIDTH-1:0]  next_win_c;
  logic              hit_c;

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (din_valid),
    .din (din),
    .q   (win)
  );

  // Compare against the window as it will look after this edge.
  assign next_win_c = {win[WIDTH-2:0], din};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      armed_q <= 1'b0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    hit_c   = 1'b0;

    if (din_valid) begin
      hit_c = (next_win_c == PATTERN) &&
              ((state_q == ST_ARMED) || (fill_q == FILL_LAST));
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
      if (fill_q == FILL_LAST) begin
        state_d = ST_ARMED;
      end
      // Non-overlapping mode discards the window and waits for a full refill.
      if (hit_c && !OVERLAP) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end
    end

    match_d = hit_c;
    armed_d = (state_d == ST_ARMED);

    // A clear coinciding with a match keeps that match.
    if (clear_cnt) begin
      cnt_d = CNT_W'(hit_c);
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign window    = win;
  assign armed     = armed_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Serial pattern detector; sits directly downstream of the single-bit D flip-flop stage and consumes its registered Q output as a serial bit stream.
- Shifts qualified bits into a window register and compares the window against a fixed pattern.
- Emits a one-cycle match pulse, a saturating match counter and the parallel window contents.
- Used in the sequential-logic lab chain: flip-flop, then detector, then display/LED logic.

Parameters:
- WIDTH, 4: pattern/window length in bits, 2..16.
- PATTERN, 4'b1011: target sequence; MSB is the oldest bit received.
- CNT_W, 8: match counter width.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = window must refill completely after a match.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- din  in  1  serial data bit, driven by the upstream flip-flop Q.
- din_valid  in  1  qualifies din; a bit is accepted only in cycles where this is 1.
- clear_cnt  in  1  synchronous clear of match_cnt.
- window  out  WIDTH  current shift-register contents, newest bit at LSB.
- armed  out  1  1 when at least WIDTH bits have been accepted since reset or since the last refill.
- match  out  1  one-cycle pulse on detection.
- match_cnt  out  CNT_W  saturating count of detections.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk. All outputs are registered.
- Reset values: window=0, armed=0, match=0, match_cnt=0, fill counter=0, FSM=FILL. Reset overrides all other inputs in the same cycle, including mid-stream; partial windows are discarded.
- Shift: when din_valid=1, window <= {window[WIDTH-2:0], din}. When din_valid=0, window holds. Gaps in din_valid do not break a sequence.
- Fill counter: width ceil(log2(WIDTH+1)). Increments on each accepted bit and saturates at WIDTH.
- FSM has two states:
  - FILL: armed=0. Moves to ARMED on the accepted bit that brings the fill count to WIDTH.
  - ARMED: armed=1. Stays in ARMED when OVERLAP=1. When OVERLAP=0 and a match occurs, the fill counter goes to 0 and the FSM returns to FILL in the same edge.
- Match condition, evaluated on the next-window value: din_valid=1 AND next window == PATTERN AND (state==ARMED OR this bit completes the fill).
- Match timing: match is asserted for exactly one cycle, on the clock edge that accepts the completing bit, so it is visible in the following cycle. Latency is 1 cycle from the valid bit. match=0 in every cycle without an accepted completing bit.
- match_cnt:
  - Increments by 1 on each match and saturates at 2^CNT_W-1; there is no wrap.
  - clear_cnt=1 alone: count becomes 0.
  - clear_cnt=1 in the same cycle as a match: count becomes 1; the event is not lost.
  - clear_cnt does not affect window, armed, match or the FSM.
- din is treated as already synchronous; it comes from the upstream flip-flop, so no synchronizer is inside this block.

Decomposition:
- Shared package (seq_pkg): FSM state encoding constants ST_FILL=1'b0, ST_ARMED=1'b1; default WIDTH/PATTERN constants; a function computing the fill counter width.
- One sub-module: sipo_shreg. It is the WIDTH-bit serial-in parallel-out shift register with enable, with ports clk, rst, en, din, q.
- FSM, fill counter, compare logic and match counter live in seq_detector.

Test Plan:
- Overlap detect: OVERLAP=1, din_valid=1 every cycle, bits 1,0,1,1,0,1,1 -> match pulses after bit 4 and after bit 7; match_cnt=2; window=4'b1011.
- Non-overlap: OVERLAP=0, same stream -> single match after bit 4; armed drops to 0 for bits 5-7; match_cnt=1.
- Valid gaps: bits 1,0,1,1 with din_valid=0 for 3 cycles between each bit -> exactly one match, 1 cycle after the fourth valid bit; window holds during gaps.
- Reset mid-stream: accept 1,0,1, assert rst one cycle, then accept 1 -> no match; window=4'b0001, armed=0. Then 0,1,1 -> match after the final bit.
- Saturation and clear: CNT_W=2, stream of 1011 repeated 5 times with OVERLAP=0 -> match_cnt stays 3. clear_cnt pulsed alone -> 0. clear_cnt coincident with a match -> 1.
- Armed timing: WIDTH=4, accept 0,0,0 -> armed=0. Accept 4th bit -> armed=1 the next cycle; window=4'b0000 (or 4'b0001 if the 4th bit is 1); match=0.
